piso_shifter: RTL and testbench

Parallel-in, serial-out shift transmitter. It accepts one WIDTH-bit word through a valid/ready load handshake and emits it one bit per clock, MSB-first or LSB-first, with a frame-valid strobe and an end-of-frame pulse. It is the transmit-side counterpart of the team's serial-in/parallel-out shift-left/shift-right register. Its bit-order convention matches that register, so a frame sent here can be captured directly by the SIPO.

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_bit_cnt.sv | 30 +++
 rtl/piso_shifter.sv | 120 ++++++++++++
 tb/tb_piso_shifter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
// The PARITY encoding stays reserved even when PISO_PARITY_EN is not defined.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    localparam int PISO_WIDTH_DEF = 8;

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable down-counter that tracks the remaining frame bits.
// Exposes only a terminal-count flag, so the FSM never handles count values directly.
module piso_bit_cnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt;

    // Load takes priority; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Terminal-count compare.
    assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in, serial-out shift transmitter, MSB-first (dir=0) or LSB-first (dir=1).
// Optional even-parity trailer bit: define PISO_PARITY_EN.
//
//   state  | meaning
//   -------+-----------------------------------------------------
//   IDLE   | load_ready=1, waiting for load_valid
//   SHIFT  | driving data bits on sout, one per clock
//   PARITY | driving the even-parity bit (PISO_PARITY_EN only)
module piso_shifter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    piso_state_t      state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             dir_q;
    logic             accept;
    logic             cnt_zero;

    // load_ready comes from state alone, so accept never loops back into it.
    assign accept = load_valid && (state == IDLE);

    piso_bit_cnt #(.CW(CW)) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (CW'(WIDTH - 1)),
        .dec      (state == SHIFT),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the word and its bit order on accept; shift toward the output end while sending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            dir_q <= 1'b0;
        end else if (accept) begin
            shreg <= din;
            dir_q <= dir;
        end else if (state == SHIFT) begin
            shreg <= dir_q ? (shreg >> 1) : (shreg << 1);
        end
    end

`ifdef PISO_PARITY_EN
    logic par_q;

    // Even parity of the accepted word, sent after the last data bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^din;
        end
    end
`endif

    // Next state and registered-state output decode.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = dir_q ? shreg[0] : shreg[WIDTH-1];
                if (cnt_zero) begin
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    done      = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
            PARITY: begin
`ifdef PISO_PARITY_EN
                sout       = par_q;
                sout_valid = 1'b1;
                done       = 1'b1;
`endif
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_shifter.sv
// Self-checking bench for piso_shifter: directed table, hand-written corner
// sequences and randomized frames against a bit-stream reference model.
module tb_piso_shifter;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = W + PAR;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] din;
    logic         dir;
    logic         sout;
    logic         sout_valid;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    piso_shifter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .din        (din),
        .dir        (dir),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    // stream: bits in transmit order, stream[W-1] first on the wire
    typedef struct {
        logic [W-1:0] din;
        logic         dir;
        logic [W-1:0] stream;
        logic         par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wire order from first principles: MSB-first sends din[W-1] first, LSB-first sends din[0] first.
    function automatic logic [W-1:0] model_stream(input logic [W-1:0] d, input logic r);
        logic [W-1:0] s;
        for (int i = 0; i < W; i++) begin
            s[W-1-i] = r ? d[i] : d[W-1-i];
        end
        return s;
    endfunction

    task automatic check_idle(input string name);
        chk({name, "_idle_valid"}, sout_valid, 0);
        chk({name, "_idle_sout"}, sout, 0);
        chk({name, "_idle_done"}, done, 0);
        chk({name, "_idle_ready"}, load_ready, 1);
    endtask

    // Called at the negedge where the first frame bit should be on sout; returns at the last bit.
    task automatic check_bits(input logic [W-1:0] stream, input logic par, input string name);
        logic exp_bit;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            exp_bit = (i < W) ? stream[W-1-i] : par;
            chk($sformatf("%s_bit%0d", name, i), sout, exp_bit);
            chk($sformatf("%s_valid%0d", name, i), sout_valid, 1);
            chk($sformatf("%s_done%0d", name, i), done, (i == FL-1) ? 1 : 0);
            chk($sformatf("%s_ready%0d", name, i), load_ready, 0);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready_wait"}, load_ready, 1);
    endtask

    // One isolated frame; dir and din are scrambled after accept to show they are not re-sampled.
    task automatic send_frame(input logic [W-1:0] d, input logic r,
                              input logic [W-1:0] stream, input logic par, input string name);
        wait_ready(name);
        load_valid = 1'b1;
        din        = d;
        dir        = r;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        dir        = ~r;
        din        = W'($urandom);
        check_bits(stream, par, name);
        @(negedge clk);
        check_idle(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{din: 8'hC1, dir: 1'b0, stream: 8'b1100_0001, par: 1'b1};
        vecs[1] = '{din: 8'hC1, dir: 1'b1, stream: 8'b1000_0011, par: 1'b1};
        vecs[2] = '{din: 8'h07, dir: 1'b0, stream: 8'b0000_0111, par: 1'b1};
        vecs[3] = '{din: 8'h03, dir: 1'b0, stream: 8'b0000_0011, par: 1'b0};
        vecs[4] = '{din: 8'h0F, dir: 1'b0, stream: 8'b0000_1111, par: 1'b0};
        vecs[5] = '{din: 8'h0F, dir: 1'b1, stream: 8'b1111_0000, par: 1'b0};
        vecs[6] = '{din: 8'hA5, dir: 1'b1, stream: 8'b1010_0101, par: 1'b0};
        vecs[7] = '{din: 8'h80, dir: 1'b1, stream: 8'b0000_0001, par: 1'b1};

        reset      = 1'b1;
        load_valid = 1'b0;
        din        = '0;
        dir        = 1'b0;
        #1;
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        foreach (vecs[k]) begin
            send_frame(vecs[k].din, vecs[k].dir, vecs[k].stream, vecs[k].par,
                       $sformatf("vec%0d", k));
        end

        // Back-to-back: load_valid held high with a different word throughout the frame.
        begin
            logic [W-1:0] a, b;
            a = 8'h96;
            b = 8'h3C;
            wait_ready("b2b");
            load_valid = 1'b1;
            din        = a;
            dir        = 1'b0;
            @(posedge clk);
            @(negedge clk);
            din = b;
            check_bits(model_stream(a, 1'b0), ^a, "b2b_a");
            @(negedge clk);
            check_idle("b2b_gap");
            @(posedge clk);
            @(negedge clk);
            load_valid = 1'b0;
            check_bits(model_stream(b, 1'b0), ^b, "b2b_b");
            @(negedge clk);
            check_idle("b2b_end");
        end

        // Reset on the 4th bit of an 8'hFF frame, then a clean 8'h0F frame.
        wait_ready("rst_mid");
        load_valid = 1'b1;
        din        = 8'hFF;
        dir        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("rst_mid_bit%0d", i), sout, 1);
        end
        reset = 1'b1;
        #1;
        check_idle("rst_mid_async");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("rst_mid_after");
        send_frame(8'h0F, 1'b0, 8'b0000_1111, 1'b0, "rst_next");

        // Randomized frames against the reference model.
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] d;
            logic         r;
            d = W'($urandom);
            r = 1'($urandom_range(0, 1));
            send_frame(d, r, model_stream(d, r), ^d, $sformatf("rnd%0d", k));
        end

        // load_valid held through reset deassertion: accepted at first edge with reset low.
        @(negedge clk);
        reset      = 1'b1;
        load_valid = 1'b1;
        din        = 8'h5A;
        dir        = 1'b0;
        @(negedge clk);
        chk("rel_in_reset_valid", sout_valid, 0);
        reset = 1'b0;
        chk("rel_ready", load_ready, 1);
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        check_bits(model_stream(8'h5A, 1'b0), ^(8'h5A), "rel");
        @(negedge clk);
        check_idle("rel_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
